// File: rtl/enc_lane_scheduler_if.sv
// Requester/control bundle between byte-stream sources and the two-lane encoder scheduler.
// Latency: none (wires only); all timing is owned by enc_lane_scheduler.
// Backpressure: requesters see rd_en as their pop strobe; no other stall path exists.
interface enc_lane_scheduler_if #(
    parameter int NUM_REQ = 3
) ();
    logic                   enable;
    logic [1:0]             gen_speed;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ-1:0]     req_last;
    logic [4*NUM_REQ-1:0]   req_dsel;
    logic [8*NUM_REQ-1:0]   lane0_in;
    logic [8*NUM_REQ-1:0]   lane1_in;
    logic [NUM_REQ-1:0]     gnt;
    logic [NUM_REQ-1:0]     rd_en;
    logic [7:0]             lane_0_tx;
    logic [7:0]             lane_1_tx;
    logic [3:0]             d_sel;
    logic                   sym_start;
    logic                   busy;

    // Requester / control side
    modport master (
        output enable, gen_speed, req, req_last, req_dsel, lane0_in, lane1_in,
        input  gnt, rd_en, lane_0_tx, lane_1_tx, d_sel, sym_start, busy
    );

    // Scheduler side
    modport slave (
        input  enable, gen_speed, req, req_last, req_dsel, lane0_in, lane1_in,
        output gnt, rd_en, lane_0_tx, lane_1_tx, d_sel, sym_start, busy
    );
endinterface

// File: rtl/enc_lane_scheduler.sv
// Arbitrates NUM_REQ byte streams onto the shared two-lane encoder path, one burst of whole symbols per grant.
// Latency: req -> gnt 1 cycle; rd_en -> lane_x_tx/d_sel/sym_start 1 cycle.
// Backpressure: none from the encoder; requesters are popped via rd_en every granted cycle.
// Optional: define ENC_SCHED_RR_EN for round-robin arbitration (default fixed priority, index 0 highest).
module enc_lane_scheduler #(
    parameter int         NUM_REQ   = 3,
    parameter logic [3:0] IDLE_DSEL = 4'h9,
    parameter int         MAX_BURST = 0
) (
    input logic                 enc_clk,
    input logic                 rst,
    enc_lane_scheduler_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [BW-1:0]      BURST_LAST = (MAX_BURST > 0) ? BW'(MAX_BURST - 1) : '0;
    localparam logic [NUM_REQ-1:0] REQ_ONE    = NUM_REQ'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [3:0]         byte_cnt_q, byte_cnt_d;
    logic [3:0]         sym_last_q, sym_last_d;
    logic [BW-1:0]      burst_cnt_q, burst_cnt_d;
    logic [7:0]         lane_0_tx_q, lane_0_tx_d;
    logic [7:0]         lane_1_tx_q, lane_1_tx_d;
    logic [3:0]         d_sel_q, d_sel_d;
    logic               sym_start_q, sym_start_d;

    logic [IW-1:0]      arb_start;
    logic [7:0]         g_lane0, g_lane1;
    logic [3:0]         g_dsel;
    logic               g_last, g_req, burst_hit, release_gnt;
    logic [NUM_REQ-1:0] others;

    // Last byte index of a symbol for a given link speed (speed 3 never reaches here).
    function automatic logic [3:0] sym_last_of(input logic [1:0] spd);
        case (spd)
            2'd0:    return 4'd0;
            2'd1:    return 4'd15;
            2'd2:    return 4'd7;
            default: return 4'd0;
        endcase
    endfunction

    // Rotate so 'start' is bit 0, keep the lowest set bit, rotate back.
    function automatic logic [NUM_REQ-1:0] arb_pick(input logic [NUM_REQ-1:0] cand,
                                                    input logic [IW-1:0]      start);
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        logic [NUM_REQ-1:0]   low;
        dbl = {cand, cand} >> start;
        rot = dbl[NUM_REQ-1:0];
        low = rot & (~rot + REQ_ONE);
        dbl = {low, low} << start;
        return dbl[2*NUM_REQ-1:NUM_REQ];
    endfunction

`ifdef ENC_SCHED_RR_EN
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    function automatic logic [IW-1:0] idx_of(input logic [NUM_REQ-1:0] oh);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) r = IW'(i);
        end
        return r;
    endfunction

    // Pointer tracks the last new grant; search begins just after it.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if ((gnt_d != '0) && (gnt_d != gnt_q)) rr_ptr_d = idx_of(gnt_d);
        arb_start = (rr_ptr_q == IW'(NUM_REQ - 1)) ? '0 : rr_ptr_q + IW'(1);
    end

    // Pointer register; reset value makes requester 0 the first winner.
    always_ff @(posedge enc_clk) begin
        if (rst) rr_ptr_q <= IW'(NUM_REQ - 1);
        else     rr_ptr_q <= rr_ptr_d;
    end
`else
    // Fixed priority: search always starts at index 0.
    always_comb begin
        arb_start = '0;
    end
`endif

    // Select the granted requester's bytes and control bits (gnt is one-hot or zero).
    always_comb begin
        g_lane0 = '0;
        g_lane1 = '0;
        g_dsel  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                g_lane0 = g_lane0 | bus.lane0_in[8*i +: 8];
                g_lane1 = g_lane1 | bus.lane1_in[8*i +: 8];
                g_dsel  = g_dsel  | bus.req_dsel[4*i +: 4];
            end
        end
        g_last      = |(bus.req_last & gnt_q);
        g_req       = |(bus.req & gnt_q);
        burst_hit   = (MAX_BURST != 0) && (burst_cnt_q == BURST_LAST);
        release_gnt = g_last || !g_req || burst_hit;
        others      = bus.req & ~gnt_q;
    end

    // Next-state: grant at idle, count bytes, decide release only on a symbol's last byte.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        byte_cnt_d  = byte_cnt_q;
        sym_last_d  = sym_last_q;
        burst_cnt_d = burst_cnt_q;
        lane_0_tx_d = '0;
        lane_1_tx_d = '0;
        d_sel_d     = IDLE_DSEL;
        sym_start_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if ((|bus.req) && (bus.gen_speed != 2'd3)) begin
                    gnt_d       = arb_pick(bus.req, arb_start);
                    state_d     = ST_XFER;
                    byte_cnt_d  = '0;
                    burst_cnt_d = '0;
                    sym_last_d  = sym_last_of(bus.gen_speed);
                end
            end
            ST_XFER: begin
                lane_0_tx_d = g_lane0;
                lane_1_tx_d = g_lane1;
                d_sel_d     = g_dsel;
                sym_start_d = (byte_cnt_q == 4'd0);
                if (byte_cnt_q == sym_last_q) begin
                    // Symbol boundary: speed and release are only looked at here.
                    byte_cnt_d = '0;
                    if (bus.gen_speed == 2'd3) begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end else if (release_gnt) begin
                        if (|others) begin
                            gnt_d       = arb_pick(others, arb_start);
                            burst_cnt_d = '0;
                            sym_last_d  = sym_last_of(bus.gen_speed);
                        end else begin
                            state_d = ST_IDLE;
                            gnt_d   = '0;
                        end
                    end else begin
                        burst_cnt_d = burst_cnt_q + BW'(1);
                        sym_last_d  = sym_last_of(bus.gen_speed);
                    end
                end else begin
                    byte_cnt_d = byte_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        // Abort truncates the symbol in flight; it is never resumed.
        if (!bus.enable) begin
            state_d     = ST_IDLE;
            gnt_d       = '0;
            byte_cnt_d  = '0;
            burst_cnt_d = '0;
            lane_0_tx_d = '0;
            lane_1_tx_d = '0;
            d_sel_d     = IDLE_DSEL;
            sym_start_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge enc_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            byte_cnt_q  <= '0;
            sym_last_q  <= '0;
            burst_cnt_q <= '0;
            lane_0_tx_q <= '0;
            lane_1_tx_q <= '0;
            d_sel_q     <= IDLE_DSEL;
            sym_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            byte_cnt_q  <= byte_cnt_d;
            sym_last_q  <= sym_last_d;
            burst_cnt_q <= burst_cnt_d;
            lane_0_tx_q <= lane_0_tx_d;
            lane_1_tx_q <= lane_1_tx_d;
            d_sel_q     <= d_sel_d;
            sym_start_q <= sym_start_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rd_en     = (state_q == ST_XFER) ? gnt_q : '0;
    assign bus.lane_0_tx = lane_0_tx_q;
    assign bus.lane_1_tx = lane_1_tx_q;
    assign bus.d_sel     = d_sel_q;
    assign bus.sym_start = sym_start_q;
    assign bus.busy      = (state_q != ST_IDLE);
endmodule
